bin_to_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the iterative double-dabble method.
- Performs one shift-and-correct step per clock instead of the fully unrolled combinational loop.
- Drives the 7-segment digit decoders and the UART decimal print path.
- Uses a start/busy/done handshake, a registered result, and an overflow flag for values that do not fit in DIGITS decimal digits.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_DONE  = DONE
   } state_t;

   // Smallest n with 2**n >= value; used to size the shift counter.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span * 2;
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adjusted
);

   assign adjusted = (digit >= ADJ_THRESH) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock, start/busy/done handshake.
// Optional leading-zero blank mask enabled by macro BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 4
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [BIN_W-1:0]        bin,
   output logic                    busy,
   output logic                    done,
   output logic [DIGIT_W*DIGITS-1:0] bcd,
   output logic                    overflow,
   output logic [DIGITS-1:0]       blank
);

   localparam int ACC_W = DIGIT_W * DIGITS;
   localparam int CNT_W = clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_W - 1);

   state_t state;
   state_t state_next;

   logic [BIN_W-1:0] op;
   logic [BIN_W-1:0] op_shift;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_adj;
   logic [ACC_W-1:0] acc_shift;
   logic             ovf_acc;
   logic             ovf_shift;
   logic             carry_out;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             last_shift;

   assign accept     = ((state == ST_IDLE) || (state == ST_DONE)) && start;
   assign last_shift = (state == ST_SHIFT) && (count == LAST_COUNT);
   assign busy       = (state == ST_SHIFT);
   assign done       = (state == ST_DONE);

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (acc[k*DIGIT_W +: DIGIT_W]),
         .adjusted (acc_adj[k*DIGIT_W +: DIGIT_W])
      );
   end

   // Whatever leaves the accumulator MSB is a multiple of 10**DIGITS, so dropping it keeps bcd well-formed.
   assign {carry_out, acc_shift, op_shift} = {acc_adj, op, 1'b0};
   assign ovf_shift = ovf_acc | carry_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = ST_IDLE;
      case (state)
         ST_IDLE,
         ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_next = last_shift ? ST_DONE : ST_SHIFT;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op       <= '0;
         acc      <= '0;
         ovf_acc  <= 1'b0;
         count    <= '0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         op      <= bin;
         acc     <= '0;
         ovf_acc <= 1'b0;
         count   <= '0;
      end else if (state == ST_SHIFT) begin
         op      <= op_shift;
         acc     <= acc_shift;
         ovf_acc <= ovf_shift;
         count   <= count + CNT_W'(1);
         if (last_shift) begin
            bcd      <= acc_shift;
            overflow <= ovf_shift;
         end
      end
   end

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_next;
   logic [DIGITS-1:0] blank_reg;

   // Walk down from the top digit; a digit is blanked while everything above and including it is zero.
   always_comb begin : blank_calc
      logic upper_zero;
      blank_next = '0;
      upper_zero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         upper_zero    = upper_zero && (acc_shift[k*DIGIT_W +: DIGIT_W] == '0);
         blank_next[k] = upper_zero;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blank_reg <= '0;
      end else if (last_shift) begin
         blank_reg <= blank_next;
      end
   end

   assign blank = blank_reg;
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 12-bit/4-digit instance plus a 14-bit/3-digit overflow instance.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        reset_n;
   logic        start_a;
   logic [11:0] bin_a;
   logic        busy_a;
   logic        done_a;
   logic [15:0] bcd_a;
   logic        overflow_a;
   logic [3:0]  blank_a;

   logic        start_b;
   logic [13:0] bin_b;
   logic        busy_b;
   logic        done_b;
   logic [11:0] bcd_b;
   logic        overflow_b;
   logic [2:0]  blank_b;

   int errors = 0;
   int checks = 0;

   bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start_a),
      .bin      (bin_a),
      .busy     (busy_a),
      .done     (done_a),
      .bcd      (bcd_a),
      .overflow (overflow_a),
      .blank    (blank_a)
   );

   bin_to_bcd_seq #(.BIN_W(14), .DIGITS(3)) dut_b (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start_b),
      .bin      (bin_b),
      .busy     (busy_b),
      .done     (done_b),
      .bcd      (bcd_b),
      .overflow (overflow_b),
      .blank    (blank_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain decimal arithmetic on the operand value.
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [63:0] model_bcd(input longint unsigned value, input int digits);
      logic [63:0] r;
      longint unsigned v;
      r = '0;
      v = value;
      for (int k = 0; k < digits; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] model_ovf(input longint unsigned value, input int digits);
      return (value >= pow10(digits)) ? 64'd1 : 64'd0;
   endfunction

   function automatic logic [63:0] model_blank(input longint unsigned value, input int digits);
      logic [63:0] r;
      r = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      for (int k = 1; k < digits; k++) begin
         r[k] = ((value % pow10(digits)) < pow10(k));
      end
`endif
      return r;
   endfunction

   function automatic logic [63:0] digits_ok(input logic [63:0] b, input int digits);
      for (int k = 0; k < digits; k++) begin
         if (b[4*k +: 4] > 4'd9) return 64'd0;
      end
      return 64'd1;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Starts one conversion on instance a (which=0) or b (which=1); returns edges from accept to done.
   task automatic apply_stimulus(input int which, input longint unsigned value, output int latency);
      logic d;
      @(negedge clk);
      if (which == 0) begin start_a = 1'b1; bin_a = 12'(value); end
      else            begin start_b = 1'b1; bin_b = 14'(value); end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      bin_a   = 12'($urandom);
      bin_b   = 14'($urandom);
      latency = 0;
      while (latency < 40) begin
         @(posedge clk);
         latency++;
         @(negedge clk);
         d = (which == 0) ? done_a : done_b;
         if (d) break;
      end
   endtask

   task automatic run_and_check(input int which, input longint unsigned value);
      int lat;
      int digits;
      digits = (which == 0) ? 4 : 3;
      apply_stimulus(which, value, lat);
      if (which == 0) begin
         check_output("latency_a", 64'(lat), 64'd12);
         check_output("bcd_a", 64'(bcd_a), model_bcd(value, digits));
         check_output("overflow_a", 64'(overflow_a), model_ovf(value, digits));
         check_output("blank_a", 64'(blank_a), model_blank(value, digits));
         check_output("digits_a", digits_ok(64'(bcd_a), digits), 64'd1);
         @(negedge clk);
         check_output("done_width_a", 64'(done_a), 64'd0);
      end else begin
         check_output("latency_b", 64'(lat), 64'd14);
         check_output("bcd_b", 64'(bcd_b), model_bcd(value, digits));
         check_output("overflow_b", 64'(overflow_b), model_ovf(value, digits));
         check_output("blank_b", 64'(blank_b), model_blank(value, digits));
         check_output("digits_b", digits_ok(64'(bcd_b), digits), 64'd1);
         @(negedge clk);
         check_output("done_width_b", 64'(done_b), 64'd0);
      end
   endtask

   initial begin
      int lat;
      int done_seen;

      reset_n = 1'b0;
      start_a = 1'b0;
      bin_a   = '0;
      start_b = 1'b0;
      bin_b   = '0;
      #12;
      check_output("rst_busy", 64'(busy_a), 64'd0);
      check_output("rst_done", 64'(done_a), 64'd0);
      check_output("rst_bcd", 64'(bcd_a), 64'd0);
      check_output("rst_overflow", 64'(overflow_a), 64'd0);
      check_output("rst_blank", 64'(blank_a), 64'd0);
      check_output("rst_bcd_b", 64'(bcd_b), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] directed conversions");
      run_and_check(0, 0);
      run_and_check(0, 4095);
      run_and_check(0, 999);
      run_and_check(1, 1234);
      run_and_check(1, 999);
      run_and_check(1, 16383);
      run_and_check(1, 1000);
      for (int i = 0; i < 20; i++) run_and_check(1, longint'($urandom_range(16383, 0)));

      $display("[TB] back-to-back with start held high");
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 12'd7;
      @(posedge clk);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 3) bin_a = 12'd8;
         if (done_a) break;
      end
      check_output("b2b_lat1", 64'(lat), 64'd12);
      check_output("b2b_bcd1", 64'(bcd_a), model_bcd(7, 4));
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done_a) break;
      end
      start_a = 1'b0;
      check_output("b2b_lat2", 64'(lat), 64'd13);
      check_output("b2b_bcd2", 64'(bcd_a), model_bcd(8, 4));
      @(negedge clk);
      check_output("b2b_done_off", 64'(done_a), 64'd0);
      check_output("b2b_idle", 64'(busy_a), 64'd0);

      $display("[TB] start pulse during shift is ignored");
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 12'd100;
      @(posedge clk);
      #1 start_a = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 5) begin start_a = 1'b1; bin_a = 12'd200; end
         if (lat == 6) start_a = 1'b0;
         if (done_a) break;
      end
      check_output("ign_lat", 64'(lat), 64'd12);
      check_output("ign_bcd", 64'(bcd_a), model_bcd(100, 4));
      @(negedge clk);
      check_output("ign_idle", 64'(busy_a), 64'd0);

      $display("[TB] asynchronous reset mid-conversion");
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 12'd555;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_output("abort_busy", 64'(busy_a), 64'd0);
      check_output("abort_done", 64'(done_a), 64'd0);
      check_output("abort_bcd", 64'(bcd_a), 64'd0);
      check_output("abort_overflow", 64'(overflow_a), 64'd0);
      check_output("abort_blank", 64'(blank_a), 64'd0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_a) done_seen++;
      end
      reset_n = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (done_a) done_seen++;
      end
      check_output("abort_no_done", 64'(done_seen), 64'd0);
      run_and_check(0, 321);

      $display("[TB] exhaustive sweep of the 12-bit instance");
      for (int v = 0; v < 4096; v++) run_and_check(0, longint'(v));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
